// File: rtl/rgb565_pwm_led.sv
// rgb565_pwm_led: drives the board RGB LEDs with 8-bit PWM so that they show
// the same RGB565 color that is sent to the ILI9341 panel.
//
// Parameters:
//   PRESCALE      clk cycles per PWM tick (>= 1)
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   color_in      RGB565 color: [15:11] R5, [10:5] G6, [4:0] B5
//   color_valid   color_in is valid this cycle
//   color_ready   a color can be accepted (pending buffer empty)
//   red/green/blue  registered LED drives, active-high
//   period_start  one-cycle pulse in the first cycle of each PWM period
//
// A new color is held in a one-deep pending buffer and copied into the
// active register only at a PWM period boundary, so a period never mixes
// two colors.
module rgb565_pwm_led #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] color_in,
  input  logic        color_valid,
  output logic        color_ready,
  output logic        red,
  output logic        green,
  output logic        blue,
  output logic        period_start
);

  localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned COLOR_W = 16;

  logic [PRE_W-1:0]   pre;
  logic [CNT_W-1:0]   cnt;
  logic [COLOR_W-1:0] active;
  logic [COLOR_W-1:0] pending;
  logic               pending_full;

  logic               tick;
  logic               boundary;
  logic               accept;
  logic [CNT_W-1:0]   duty_r;
  logic [CNT_W-1:0]   duty_g;
  logic [CNT_W-1:0]   duty_b;

  // Ready is forced high while in reset so the source never sees a stale
  // full flag; handshakes during reset are ignored anyway.
  assign color_ready = rst | ~pending_full;

  assign tick     = (pre == PRE_W'(PRESCALE - 1));
  assign boundary = tick && (cnt == CNT_W'(255));
  assign accept   = color_valid && !pending_full;

  // Expand each channel to 8 bits by replicating its MSBs into the LSBs,
  // so zero stays 0x00 and full scale reaches 0xFF.
  assign duty_r = {active[15:11], active[15:13]};
  assign duty_g = {active[10:5],  active[10:9]};
  assign duty_b = {active[4:0],   active[4:2]};

  // Prescaler and PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + CNT_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Pending buffer and boundary-aligned color update. An accept can only
  // happen while the buffer is empty, so it never collides with a boundary
  // that drains a full buffer; an accept on a boundary waits a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      if (boundary && pending_full) begin
        active <= pending;
      end
      if (accept) begin
        pending      <= color_in;
        pending_full <= 1'b1;
      end else if (boundary) begin
        pending_full <= 1'b0;
      end
    end
  end

  // Registered compare; outputs lag cnt/active by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      red          <= 1'b0;
      green        <= 1'b0;
      blue         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      red          <= (cnt < duty_r);
      green        <= (cnt < duty_g);
      blue         <= (cnt < duty_b);
      period_start <= boundary;
    end
  end

endmodule

// File: tb/tb_rgb565_pwm_led.sv
// Bench for rgb565_pwm_led: two instances (PRESCALE=1 and PRESCALE=3) share
// clock and reset. A time-based reference model predicts every output on
// every cycle; directed sequences measure per-period high times, spacing
// of period_start, backpressure and reset behaviour.
module tb_rgb565_pwm_led;

  localparam int unsigned P0 = 1;
  localparam int unsigned P1 = 3;

  logic        clk;
  logic        rst;
  logic [15:0] cin [2];
  logic        val [2];
  logic        rdy [2];
  logic        r   [2];
  logic        g   [2];
  logic        b   [2];
  logic        ps  [2];

  int checks = 0;
  int errors = 0;

  rgb565_pwm_led #(.PRESCALE(P0)) dut0 (
    .clk(clk), .rst(rst), .color_in(cin[0]), .color_valid(val[0]),
    .color_ready(rdy[0]), .red(r[0]), .green(g[0]), .blue(b[0]),
    .period_start(ps[0])
  );

  rgb565_pwm_led #(.PRESCALE(P1)) dut1 (
    .clk(clk), .rst(rst), .color_in(cin[1]), .color_valid(val[1]),
    .color_ready(rdy[1]), .red(r[1]), .green(g[1]), .blue(b[1]),
    .period_start(ps[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pres(input int d);
    return (d == 0) ? int'(P0) : int'(P1);
  endfunction

  // Duty values as plain arithmetic on the channel codes.
  function automatic int duty_r(input logic [15:0] c);
    int v;
    v = int'(c[15:11]);
    return v * 8 + v / 4;
  endfunction
  function automatic int duty_g(input logic [15:0] c);
    int v;
    v = int'(c[10:5]);
    return v * 4 + v / 16;
  endfunction
  function automatic int duty_b(input logic [15:0] c);
    int v;
    v = int'(c[4:0]);
    return v * 8 + v / 4;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts clocked cycles since reset; the PWM position
  // and period boundaries follow directly from t and PRESCALE.
  int          m_t   [2] = '{0, 0};
  bit          m_pf  [2] = '{0, 0};
  logic [15:0] m_pnd [2] = '{16'h0, 16'h0};
  logic [15:0] m_act [2] = '{16'h0, 16'h0};
  bit          e_r   [2] = '{0, 0};
  bit          e_g   [2] = '{0, 0};
  bit          e_b   [2] = '{0, 0};
  bit          e_ps  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_t[d] = 0; m_pf[d] = 0; m_act[d] = 16'h0;
        e_r[d] = 0; e_g[d] = 0; e_b[d] = 0; e_ps[d] = 0;
      end else begin
        int per, phase, pos;
        bit bnd, acc;
        per   = 256 * pres(d);
        phase = m_t[d] % per;
        pos   = phase / pres(d);
        bnd   = (phase == per - 1);
        acc   = val[d] && !m_pf[d];
        e_r[d]  = pos < duty_r(m_act[d]);
        e_g[d]  = pos < duty_g(m_act[d]);
        e_b[d]  = pos < duty_b(m_act[d]);
        e_ps[d] = bnd;
        if (bnd && m_pf[d]) begin
          m_act[d] = m_pnd[d];
          m_pf[d]  = 0;
        end
        if (acc) begin
          m_pnd[d] = cin[d];
          m_pf[d]  = 1;
        end
        m_t[d]++;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_red0",   int'(r[0]),   int'(e_r[0]));
    chk("model_green0", int'(g[0]),   int'(e_g[0]));
    chk("model_blue0",  int'(b[0]),   int'(e_b[0]));
    chk("model_ps0",    int'(ps[0]),  int'(e_ps[0]));
    chk("model_rdy0",   int'(rdy[0]), int'(rst || !m_pf[0]));
    chk("model_red1",   int'(r[1]),   int'(e_r[1]));
    chk("model_green1", int'(g[1]),   int'(e_g[1]));
    chk("model_blue1",  int'(b[1]),   int'(e_b[1]));
    chk("model_ps1",    int'(ps[1]),  int'(e_ps[1]));
    chk("model_rdy1",   int'(rdy[1]), int'(rst || !m_pf[1]));
  end

  // Waits for the next period_start; n is the number of cycles advanced.
  task automatic wait_ps(input int d, output int n);
    n = 0;
    for (int i = 0; i < 256 * pres(d) + 8; i++) begin
      @(negedge clk);
      n++;
      if (ps[d]) return;
    end
    chk("ps_timeout", 0, 1);
  endtask

  // Offers a color until accepted (bounded); returns just after the
  // accepting edge. ps_at_acc reports period_start in the accepting cycle.
  task automatic send(input int d, input logic [15:0] c, output bit ps_at_acc);
    ps_at_acc = 0;
    @(posedge clk); #2;
    cin[d] = c;
    val[d] = 1'b1;
    for (int i = 0; i < 256 * pres(d) + 8; i++) begin
      if (rdy[d]) begin
        ps_at_acc = ps[d];
        @(posedge clk); #2;
        val[d] = 1'b0;
        return;
      end
      @(posedge clk); #2;
    end
    val[d] = 1'b0;
    chk("send_timeout", 0, 1);
  endtask

  // Measures one full period starting right after a period_start negedge.
  task automatic measure(input int d, output int hr, output int hg,
                         output int hb, output bit contig);
    hr = 0; hg = 0; hb = 0; contig = 1;
    for (int i = 0; i < 256 * pres(d); i++) begin
      @(negedge clk);
      if (r[d]) begin if (hr != i) contig = 0; hr++; end
      if (g[d]) begin if (hg != i) contig = 0; hg++; end
      if (b[d]) begin if (hb != i) contig = 0; hb++; end
    end
  endtask

  typedef struct {
    logic [15:0] color;
    int          dr;
    int          dg;
    int          db;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n, hr, hg, hb, highs;
    bit contig, pa;

    vecs[0] = '{16'hF800, 255,   0,   0};
    vecs[1] = '{16'h8410, 132, 130, 132};
    vecs[2] = '{16'h001F,   0,   0, 255};
    vecs[3] = '{16'h07E0,   0, 255,   0};
    vecs[4] = '{16'hFFFF, 255, 255, 255};
    vecs[5] = '{16'h0821,   8,   4,   8};
    vecs[6] = '{16'h0000,   0,   0,   0};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cin[d] = 16'h0;
      val[d] = 1'b0;
    end

    // Reset idle.
    repeat (5) @(posedge clk);
    #2;
    chk("reset_ready", int'(rdy[0]), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_red", int'(r[0]), 0);
    wait_ps(0, n);
    chk("first_ps_delay", n, 256);
    wait_ps(0, n);
    chk("ps_spacing", n, 256);
    highs = 0;
    for (int i = 0; i < 88; i++) begin
      @(negedge clk);
      if (r[0] || g[0] || b[0]) highs++;
    end
    chk("idle_dark", highs, 0);

    // Table-driven colors: send at a period start, measure the next period.
    for (int v = 0; v < 7; v++) begin
      wait_ps(0, n);
      send(0, vecs[v].color, pa);
      wait_ps(0, n);
      measure(0, hr, hg, hb, contig);
      chk("vec_red_high",   hr, vecs[v].dr);
      chk("vec_green_high", hg, vecs[v].dg);
      chk("vec_blue_high",  hb, vecs[v].db);
      chk("vec_contig",     int'(contig), 1);
      chk("vec_ps_period",  int'(ps[0]), 1);
      chk("vec_duty_fn",    duty_r(vecs[v].color) * 65536 + duty_g(vecs[v].color) * 256
                            + duty_b(vecs[v].color),
                            vecs[v].dr * 65536 + vecs[v].dg * 256 + vecs[v].db);
    end

    // Backpressure: A accepted mid-period, B held until the boundary.
    wait_ps(0, n);
    repeat (48) @(posedge clk);
    send(0, 16'h001F, pa);
    chk("bp_ready_drop", int'(rdy[0]), 0);
    send(0, 16'h07E0, pa);
    chk("bp_b_at_boundary", int'(pa), 1);
    @(negedge clk);
    chk("bp_a_active_blue",  int'(b[0]), 1);
    chk("bp_a_active_green", int'(g[0]), 0);
    wait_ps(0, n);
    measure(0, hr, hg, hb, contig);
    chk("bp_b_green", hg, 255);
    chk("bp_b_blue",  hb, 0);

    // Reset mid-period with white active and a color pending.
    wait_ps(0, n);
    send(0, 16'hFFFF, pa);
    wait_ps(0, n);
    send(0, 16'h1234, pa);
    repeat (98) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("rst_mid_ready", int'(rdy[0]), 1);
    @(negedge clk);
    chk("rst_mid_leds", int'(r[0] || g[0] || b[0]), 0);
    highs = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (r[0] || g[0] || b[0]) highs++;
    end
    chk("rst_mid_stays_black", highs, 0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      val[0] = ($urandom_range(7) == 0);
      cin[0] = 16'($urandom);
    end
    @(posedge clk); #2;
    val[0] = 1'b0;

    // PRESCALE=3 instance.
    wait_ps(1, n);
    send(1, 16'h8410, pa);
    wait_ps(1, n);
    measure(1, hr, hg, hb, contig);
    chk("p3_red_high",   hr, 396);
    chk("p3_green_high", hg, 390);
    chk("p3_blue_high",  hb, 396);
    chk("p3_contig",     int'(contig), 1);
    chk("p3_ps_period",  int'(ps[1]), 1);
    wait_ps(1, n);
    chk("p3_ps_spacing", n, 768);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
